// File: rtl/rtc_scan_menu_ctrl.sv
// RTC scan/menu controller: periodic read sweeps over a two-segment address map, write sweeps
// on commit, edit pointer, button pulse registers and IRQ alarm stretching.
module rtc_scan_menu_ctrl #(
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] SEG0_FIRST = 8'h21,
    parameter logic [ADDR_W-1:0] SEG0_LAST  = 8'h26,
    parameter logic [ADDR_W-1:0] SEG1_FIRST = 8'h41,
    parameter logic [ADDR_W-1:0] SEG1_LAST  = 8'h43,
    parameter int unsigned       WAIT_CYC   = 40,
    parameter int unsigned       ALARM_CYC  = 3,
    parameter int unsigned       CNT_W      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init_done,
    input  logic              rw_done,
    input  logic              irq,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_center,
    output logic              req,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              commit,
    output logic [ADDR_W-1:0] punt,
    output logic              num_up,
    output logic              num_down,
    output logic              alarm,
    output logic              stw
);

    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYC - 1);

    typedef enum logic [2:0] {StInit, StIssue, StWaitAck, StNext, StScanWait} scan_state_e;
    typedef enum logic {AlIdle, AlOn} alarm_state_e;

    scan_state_e      state;
    logic             pend;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= StInit;
            req      <= 1'b0;
            wr       <= 1'b0;
            addr     <= SEG0_FIRST;
            busy     <= 1'b0;
            commit   <= 1'b0;
            pend     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            req    <= 1'b0;
            commit <= 1'b0;
            if (btn_center) pend <= 1'b1;
            case (state)
                StInit: begin
                    if (init_done) begin
                        state <= StIssue;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                        addr  <= SEG0_FIRST;
                        wr    <= 1'b0;
                    end
                end
                StIssue: state <= StWaitAck;
                StWaitAck: begin
                    if (rw_done) state <= StNext;
                end
                StNext: begin
                    if (addr == SEG0_LAST) begin
                        addr  <= SEG1_FIRST;
                        state <= StIssue;
                        req   <= 1'b1;
                    end else if (addr == SEG1_LAST) begin
                        addr <= SEG0_FIRST;
                        if (!wr && pend) begin
                            // Request is consumed at launch so a press during the write re-arms it
                            wr    <= 1'b1;
                            pend  <= btn_center;
                            state <= StIssue;
                            req   <= 1'b1;
                        end else begin
                            commit   <= wr;
                            wr       <= 1'b0;
                            busy     <= 1'b0;
                            wait_cnt <= '0;
                            state    <= StScanWait;
                        end
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= StIssue;
                        req   <= 1'b1;
                    end
                end
                StScanWait: begin
                    if (pend) begin
                        wr    <= 1'b1;
                        pend  <= btn_center;
                        state <= StIssue;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= StIssue;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            punt <= SEG0_FIRST;
        end else if (btn_center) begin
            punt <= SEG0_FIRST;
        end else if (btn_right && !btn_left) begin
            if (punt == SEG0_LAST)      punt <= SEG1_FIRST;
            else if (punt == SEG1_LAST) punt <= SEG0_FIRST;
            else                        punt <= punt + ADDR_W'(1);
        end else if (btn_left && !btn_right) begin
            if (punt == SEG1_FIRST)      punt <= SEG0_LAST;
            else if (punt == SEG0_FIRST) punt <= SEG1_LAST;
            else                         punt <= punt - ADDR_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            num_up   <= 1'b0;
            num_down <= 1'b0;
        end else begin
            num_up   <= btn_up;
            num_down <= btn_down;
        end
    end

    alarm_state_e     al_state;
    logic [CNT_W-1:0] al_cnt;
    logic             irq_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            al_state <= AlIdle;
            al_cnt   <= '0;
            irq_q    <= 1'b0;
            alarm    <= 1'b0;
            stw      <= 1'b0;
        end else begin
            irq_q <= irq;
            case (al_state)
                AlIdle: begin
                    if (irq && !irq_q) begin
                        al_state <= AlOn;
                        al_cnt   <= '0;
                        alarm    <= 1'b1;
                        stw      <= (ALARM_LAST == '0);
                    end
                end
                AlOn: begin
                    if (al_cnt == ALARM_LAST) begin
                        al_state <= AlIdle;
                        alarm    <= 1'b0;
                        stw      <= 1'b0;
                    end else begin
                        al_cnt <= al_cnt + CNT_W'(1);
                        stw    <= (al_cnt + CNT_W'(1) == ALARM_LAST);
                    end
                end
                default: al_state <= AlIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_scan_menu_ctrl.sv
// Self-checking bench for rtc_scan_menu_ctrl: sweep/commit scoreboard, pointer, button and alarm
// models checked every cycle, plus directed literal expectations.
module tb_rtc_scan_menu_ctrl;

    localparam int WAIT_CYC  = 40;
    localparam int ALARM_CYC = 3;
    localparam int ACK_DLY   = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       init_done, rw_done, irq;
    logic       btn_up, btn_down, btn_left, btn_right, btn_center;
    logic       req, wr, busy, commit, num_up, num_down, alarm, stw;
    logic [7:0] addr, punt;

    int checks = 0;
    int errors = 0;

    rtc_scan_menu_ctrl #(
        .ADDR_W    (8),
        .SEG0_FIRST(8'h21),
        .SEG0_LAST (8'h26),
        .SEG1_FIRST(8'h41),
        .SEG1_LAST (8'h43),
        .WAIT_CYC  (WAIT_CYC),
        .ALARM_CYC (ALARM_CYC),
        .CNT_W     (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .init_done (init_done),
        .rw_done   (rw_done),
        .irq       (irq),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_center(btn_center),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .busy      (busy),
        .commit    (commit),
        .punt      (punt),
        .num_up    (num_up),
        .num_down  (num_down),
        .alarm     (alarm),
        .stw       (stw)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The address map as an ordered list: one sweep visits it front to back.
    logic [7:0] amap [9];
    initial begin
        for (int i = 0; i < 6; i++) amap[i] = 8'(8'h21 + i);
        for (int i = 0; i < 3; i++) amap[6 + i] = 8'(8'h41 + i);
    end

    // Reference model state updated at the clock edge.
    int   p_idx = 0;
    int   a_rem = 0;
    int   pend_seq = 0;
    logic irq_prev = 1'b0;
    logic exp_up = 1'b0;
    logic exp_down = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_idx    <= 0;
            a_rem    <= 0;
            irq_prev <= 1'b0;
            exp_up   <= 1'b0;
            exp_down <= 1'b0;
        end else begin
            exp_up   <= btn_up;
            exp_down <= btn_down;
            if (btn_center)                   p_idx <= 0;
            else if (btn_right && !btn_left)  p_idx <= (p_idx + 1) % 9;
            else if (btn_left && !btn_right)  p_idx <= (p_idx + 8) % 9;
            if (a_rem > 0)                    a_rem <= a_rem - 1;
            else if (irq && !irq_prev)        a_rem <= ALARM_CYC;
            irq_prev <= irq;
            if (btn_center) pend_seq <= pend_seq + 1;
        end
    end

    // RTC responder: acknowledge every request ACK_DLY cycles later.
    initial begin
        rw_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (req && !RST) begin
                repeat (ACK_DLY) @(negedge CLK);
                if (!RST) rw_done = 1'b1;
                @(negedge CLK);
                rw_done = 1'b0;
            end
        end
    end

    // Per-cycle compare process.
    int   cyc = 0;
    int   exp_idx = 0;
    int   last_req = 0;
    int   low_run = 0;
    int   pend_seen = 0;
    int   n_commit = 0;
    int   n_wr_req = 0;
    int   last_gap = -1;
    logic exp_wr = 1'b0;
    logic prev_busy = 1'b0;
    logic gap_valid = 1'b0;
    logic sweep_wr = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) begin
                exp_idx   = 0;
                low_run   = 0;
                prev_busy = 1'b0;
                gap_valid = 1'b0;
                sweep_wr  = 1'b0;
                pend_seen = pend_seq;
            end else begin
                chk("punt", 32'(punt), 32'(amap[p_idx]));
                chk("num_up", 32'(num_up), 32'(exp_up));
                chk("num_down", 32'(num_down), 32'(exp_down));
                chk("alarm", 32'(alarm), 32'(a_rem > 0));
                chk("stw", 32'(stw), 32'(a_rem == 1));
                chk("commit", 32'(commit), 32'(prev_busy && !busy && sweep_wr));
                if (commit) n_commit++;
                if (req) begin
                    if (exp_idx == 0) begin
                        // First sweep after init is always a read; later ones write if pressed.
                        exp_wr = gap_valid && (pend_seq != pend_seen);
                        if (exp_wr) pend_seen = pend_seq;
                        if (gap_valid && !exp_wr) begin
                            chk("scan_gap", 32'(low_run), 32'(WAIT_CYC));
                            last_gap = low_run;
                        end
                        sweep_wr  = exp_wr;
                        gap_valid = 1'b1;
                    end else begin
                        chk("req_spacing", 32'(cyc - last_req), 32'(2 + ACK_DLY));
                    end
                    chk("req_addr", 32'(addr), 32'(amap[exp_idx]));
                    chk("req_wr", 32'(wr), 32'(exp_wr));
                    chk("req_busy", 32'(busy), 32'd1);
                    if (wr) n_wr_req++;
                    last_req = cyc;
                    exp_idx  = (exp_idx + 1) % 9;
                end
                low_run   = busy ? 0 : low_run + 1;
                prev_busy = busy;
            end
        end
    end

    task automatic wait_req(input logic [7:0] a, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(req && addr == a) && n < budget);
        chk("wait_req", 32'(req && addr == a), 32'd1);
    endtask

    task automatic press(input logic r, input logic l, input logic c);
        btn_right  = r;
        btn_left   = l;
        btn_center = c;
        @(negedge CLK);
        btn_right  = 1'b0;
        btn_left   = 1'b0;
        btn_center = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n, c0, w0;
        logic ea [6];
        logic es [6];
        RST = 1'b1;
        init_done = 1'b0;
        irq = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_center = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_addr", 32'(addr), 32'h21);
        chk("rst_punt", 32'(punt), 32'h21);
        chk("rst_alarm", 32'(alarm), 32'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        chk("init_hold_busy", 32'(busy), 32'd0);

        // Periodic read sweeps with a fixed idle gap.
        init_done = 1'b1;
        wait_req(8'h21, 20);
        wait_req(8'h43, 100);
        wait_req(8'h21, 100);
        @(negedge CLK);
        chk("gap_literal", 32'(last_gap), 32'd40);

        // Commit mid read sweep: sweep finishes, then one write sweep and a commit pulse.
        wait_req(8'h24, 100);
        c0 = n_commit;
        w0 = n_wr_req;
        @(negedge CLK);
        press(1'b0, 1'b0, 1'b1);
        wait_req(8'h21, 100);
        chk("wr_sweep_wr", 32'(wr), 32'd1);
        n = 0;
        while (!commit && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("commit_seen", 32'(commit), 32'd1);
        @(negedge CLK);
        chk("commit_count", 32'(n_commit - c0), 32'd1);
        chk("wr_req_count", 32'(n_wr_req - w0), 32'd9);
        chk("after_commit_busy", 32'(busy), 32'd0);
        wait_req(8'h21, 100);
        chk("post_commit_read", 32'(wr), 32'd0);

        // Edit pointer wrap rules (presses stay inside this read sweep).
        repeat (5) press(1'b1, 1'b0, 1'b0);
        chk("punt_26", 32'(punt), 32'h26);
        press(1'b1, 1'b0, 1'b0);
        chk("punt_26_right", 32'(punt), 32'h41);
        repeat (2) press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("punt_43_right", 32'(punt), 32'h21);
        press(1'b0, 1'b1, 1'b0);
        chk("punt_21_left", 32'(punt), 32'h43);
        press(1'b1, 1'b1, 1'b0);
        chk("punt_lr", 32'(punt), 32'h43);
        press(1'b0, 1'b0, 1'b1);
        chk("punt_center", 32'(punt), 32'h21);

        // Alarm stretch; a second edge during ON and a held level are ignored.
        ea = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        es = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        irq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) irq = 1'b0;
            if (i == 1) irq = 1'b1;
            chk("alarm_lit", 32'(alarm), 32'(ea[i]));
            chk("stw_lit", 32'(stw), 32'(es[i]));
        end
        irq = 1'b0;

        // Button pulses are registered by one cycle.
        btn_up = 1'b1;
        @(negedge CLK);
        btn_up = 1'b0;
        chk("num_up_hi", 32'(num_up), 32'd1);
        chk("num_down_lo", 32'(num_down), 32'd0);
        @(negedge CLK);
        chk("num_up_lo", 32'(num_up), 32'd0);
        btn_down = 1'b1;
        @(negedge CLK);
        btn_down = 1'b0;
        chk("num_down_hi", 32'(num_down), 32'd1);
        @(negedge CLK);
        chk("num_down_lo2", 32'(num_down), 32'd0);

        // Asynchronous reset while waiting for the ack at 42.
        wait_req(8'h42, 200);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_req", 32'(req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr", 32'(wr), 32'd0);
        chk("arst_commit", 32'(commit), 32'd0);
        chk("arst_addr", 32'(addr), 32'h21);
        init_done = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("init_idle_req", 32'(req), 32'd0);
            chk("init_idle_busy", 32'(busy), 32'd0);
        end
        init_done = 1'b1;
        wait_req(8'h21, 20);
        chk("resume_wr", 32'(wr), 32'd0);
        wait_req(8'h21, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
